aes_encrypt: RTL and testbench
==============================

# aes_encrypt

Iterative AES-128 encryption core, the forward counterpart of the Lab 9 decryption core. It sits beside the decryptor behind the same START/DONE handshake. It encrypts one 128-bit block per request, computing round keys on the fly instead of storing a full 1408-bit schedule. Each transform step (SubBytes, ShiftRows, MixColumns per column, AddRoundKey) takes one clock, with the datapath sharing a single 128-bit state register.

## Interface
Parameters:
- none (fixed AES-128: 10 rounds)

Ports:
- CLK  in  1  system clock, rising-edge
- RESET  in  1  reset, asynchronous, active-high
- AES_START  in  1  level request; sampled in IDLE
- AES_DONE  out  1  high while result valid (DONE state)
- AES_KEY  in  128  cipher key; [127:120] = key byte 0
- AES_MSG_DEC  in  128  plaintext; [127:120] = byte 0, column-major, column c = [127-32c -: 32]
- AES_MSG_ENC  out  128  ciphertext register, same byte order

## Operation
- States: IDLE, LOAD, SUB, SHIFT, MIX, ADDKEY, DONE.
- IDLE, AES_START=1 → LOAD.
- LOAD:
  - state ← AES_MSG_DEC ^ AES_KEY
  - rk ← AES_KEY
  - round ← 1
  - go to SUB
  - AES_KEY and AES_MSG_DEC are sampled only at this edge.
- SUB:
  - state ← SBOX applied to all 16 bytes
  - rk ← key_step(rk, RCON[round])
  - go to SHIFT
- SHIFT:
  - row r rotated left by r bytes
  - round<10 → MIX with col←0; round=10 → ADDKEY.
- MIX:
  - column col ← MixColumns(column col), using the GF(2^8) xtime matrix [2 3 1 1]
  - col increments; after col=3 → ADDKEY.
- ADDKEY:
  - state ← state ^ rk
  - round<10: round++, go to SUB
  - round=10: AES_MSG_ENC ← state ^ rk, go to DONE
- DONE:
  - AES_DONE=1
  - hold while AES_START=1; AES_START=0 → IDLE.
- RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- AES_START held high through completion is ignored until DONE. A new block requires AES_START to go low, then high again.
- AES_MSG_ENC changes only on the ADDKEY→DONE edge. It holds the last ciphertext in IDLE and during later operations.
- RESET at any time, including mid-operation: FSM→IDLE, round/col/state/rk cleared. Any partial result is discarded.

## Timing
- Reset values: AES_DONE=0, AES_MSG_ENC=128'h0, FSM=IDLE.
- Let E0 be the edge at which AES_START=1 is sampled in IDLE.
  - LOAD occupies cycle E0→E1.
  - Rounds 1–9 take 7 cycles each: SUB, SHIFT, 4×MIX, ADDKEY.
  - Round 10 takes 3 cycles: SUB, SHIFT, ADDKEY.
  - Total: 1 + 63 + 3 = 67 cycles.
- AES_DONE rises at edge E0+67; AES_MSG_ENC is valid in the same cycle.
- AES_DONE falls one edge after AES_START is sampled low in DONE.
- Minimum back-to-back period: 69 cycles.

## Configuration
- AES_ENC_FAST_MIX_EN:
  - Defined: MIX transforms all four columns in one cycle (four MixColumns instances).
    - Rounds 1–9 take 4 cycles each.
    - AES_DONE at E0+40.
  - Undefined: one shared MixColumns instance with a column counter.
    - Latency is 67 cycles, as specified above.
  - Functional result is identical in both builds.

## Structure
- Package aes_enc_pkg holds:
  - FSM state enum
  - 256-entry SBOX constant
  - RCON constant array
  - xtime and MixColumns-column functions
- Sub-module aes_key_step: combinational single forward key-expansion step, (rk, rcon) → next rk.
  - RotWord, SubWord and rcon XOR are applied on word 3, followed by the cascaded word XORs.
  - It reuses SBOX from the package.
- Top level contains the FSM, counters, state register, rk register and output register.

## Test plan
- FIPS-197 App. B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Response: AES_DONE at E0+67 (E0+40 with FAST_MIX); AES_MSG_ENC = 3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Response: AES_MSG_ENC = 69c4e0d86a7b0430d8cdb78070b4c55a.
- Handshake:
  - Hold AES_START high 200 cycles → exactly one encryption; AES_DONE stays high until AES_START drops, then falls next edge.
  - Change AES_KEY/AES_MSG_DEC mid-run → result unchanged.
- Reset mid-run:
  - Stimulus: assert RESET at E0+30.
  - Response: immediately AES_DONE=0, AES_MSG_ENC=0, FSM IDLE.
  - Restart → correct App. B ciphertext at restart+67.
- Back-to-back:
  - Stimulus: App. B then App. C.1, with AES_START low for one cycle between.
  - Response: both ciphertexts correct; AES_MSG_ENC holds the App. B value until the C.1 completion edge.
- Round-trip:
  - Stimulus: feed the App. B ciphertext and key into the Lab 9 decryptor.
  - Response: plaintext 3243f6a8885a308d313198a2e0370734 recovered.

Source files
------------

// File: rtl/aes_enc_pkg.sv
// Shared AES-128 encryption definitions: FSM states, S-box, round constants
// and the byte-level transforms used by the datapath and key expansion.
package aes_enc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SUB    = 3'd2,
        SHIFT  = 3'd3,
        MIX    = 3'd4,
        ADDKEY = 3'd5,
        DONE   = 3'd6
    } aes_state_e;

    // Entry x of the S-box sits at bits [2047-8x -: 8]
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [79:0] RCON = 80'h0102040810204080_1b36;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] r;
        case (round)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
            4'd6, 4'd7, 4'd8, 4'd9, 4'd10: r = RCON[7'd87 - {round, 3'b000} -: 8];
            default:                       r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] blk);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(blk[127-8*i -: 8]);
        return o;
    endfunction

    // Byte i = 4*col + row; row r of column c comes from column (c+r)%4
    function automatic logic [127:0] shift_rows(input logic [127:0] blk);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = blk[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

endpackage

// File: rtl/aes_encrypt_if.sv
// START/DONE handshake and data buses shared by the AES encrypt core and its requester.
interface aes_encrypt_if;
    logic         AES_START;
    logic         AES_DONE;
    logic [127:0] AES_KEY;
    logic [127:0] AES_MSG_DEC;
    logic [127:0] AES_MSG_ENC;

    modport master (output AES_START, AES_KEY, AES_MSG_DEC, input AES_DONE, AES_MSG_ENC);
    modport slave  (input AES_START, AES_KEY, AES_MSG_DEC, output AES_DONE, AES_MSG_ENC);
endinterface

// File: rtl/aes_key_step.sv
// One forward AES-128 key-expansion step: current round key plus rcon to the next round key.
module aes_key_step
    import aes_enc_pkg::*;
(
    input  logic [127:0] rk,
    input  logic [7:0]   rcon_byte,
    output logic [127:0] next_rk
);
    logic [31:0] w0_s, w1_s, w2_s, w3_s, t_s, n0_s, n1_s, n2_s, n3_s;

    assign {w0_s, w1_s, w2_s, w3_s} = rk;
    // RotWord then SubWord on w3, rcon folded into the leading byte
    assign t_s  = {sbox(w3_s[23:16]) ^ rcon_byte, sbox(w3_s[15:8]),
                   sbox(w3_s[7:0]), sbox(w3_s[31:24])};
    assign n0_s = w0_s ^ t_s;
    assign n1_s = w1_s ^ n0_s;
    assign n2_s = w2_s ^ n1_s;
    assign n3_s = w3_s ^ n2_s;
    assign next_rk = {n0_s, n1_s, n2_s, n3_s};
endmodule

// File: rtl/aes_encrypt.sv
// Iterative AES-128 encryptor, one transform step per clock with on-the-fly key expansion.
// AES_ENC_FAST_MIX_EN: MixColumns on all four columns in one cycle instead of one per cycle.
module aes_encrypt
    import aes_enc_pkg::*;
(
    input  logic         CLK,
    input  logic         RESET,
    aes_encrypt_if.slave bus
);
    aes_state_e   fsm_r, fsm_next_s;
    logic [127:0] blk_r, rk_r, enc_r, key_next_s, mix_s;
    logic [3:0]   round_r;
    logic         done_r;

    aes_key_step u_key_step (.rk(rk_r), .rcon_byte(rcon(round_r)), .next_rk(key_next_s));

`ifdef AES_ENC_FAST_MIX_EN
    // All four columns mixed in parallel
    always_comb begin
        mix_s = blk_r;
        for (int c = 0; c < 4; c++) mix_s[127-32*c -: 32] = mix_column(blk_r[127-32*c -: 32]);
    end
`else
    logic [1:0]  col_r;
    logic [31:0] col_out_s;

    // Single shared MixColumns instance on the column selected by col_r
    always_comb begin
        mix_s     = blk_r;
        col_out_s = mix_column(blk_r[127-32*col_r -: 32]);
        case (col_r)
            2'd0:    mix_s[127:96] = col_out_s;
            2'd1:    mix_s[95:64]  = col_out_s;
            2'd2:    mix_s[63:32]  = col_out_s;
            2'd3:    mix_s[31:0]   = col_out_s;
            default: mix_s         = blk_r;
        endcase
    end

    // Column counter for the serial MIX pass
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)               col_r <= 2'd0;
        else if (fsm_r == SHIFT) col_r <= 2'd0;
        else if (fsm_r == MIX)   col_r <= col_r + 2'd1;
        else                     col_r <= col_r;
    end
`endif

    // Next-state logic
    always_comb begin
        fsm_next_s = fsm_r;
        case (fsm_r)
            IDLE:   fsm_next_s = bus.AES_START ? LOAD : IDLE;
            LOAD:   fsm_next_s = SUB;
            SUB:    fsm_next_s = SHIFT;
            SHIFT:  fsm_next_s = (round_r == 4'd10) ? ADDKEY : MIX;
`ifdef AES_ENC_FAST_MIX_EN
            MIX:    fsm_next_s = ADDKEY;
`else
            MIX:    fsm_next_s = (col_r == 2'd3) ? ADDKEY : MIX;
`endif
            ADDKEY: fsm_next_s = (round_r == 4'd10) ? DONE : SUB;
            DONE:   fsm_next_s = bus.AES_START ? DONE : IDLE;
            default: fsm_next_s = IDLE;
        endcase
    end

    // State register and registered handshake output
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fsm_r  <= IDLE;
            done_r <= 1'b0;
        end else begin
            fsm_r  <= fsm_next_s;
            done_r <= (fsm_next_s == DONE);
        end
    end

    // Datapath: block state, round key, round counter and ciphertext register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            blk_r   <= 128'h0;
            rk_r    <= 128'h0;
            round_r <= 4'd0;
            enc_r   <= 128'h0;
        end else begin
            case (fsm_r)
                LOAD: begin
                    blk_r   <= bus.AES_MSG_DEC ^ bus.AES_KEY;
                    rk_r    <= bus.AES_KEY;
                    round_r <= 4'd1;
                end
                SUB: begin
                    blk_r <= sub_bytes(blk_r);
                    rk_r  <= key_next_s;
                end
                SHIFT:  blk_r <= shift_rows(blk_r);
                MIX:    blk_r <= mix_s;
                ADDKEY: begin
                    blk_r <= blk_r ^ rk_r;
                    if (round_r == 4'd10) enc_r   <= blk_r ^ rk_r;
                    else                  round_r <= round_r + 4'd1;
                end
                default: blk_r <= blk_r;
            endcase
        end
    end

    assign bus.AES_DONE    = done_r;
    assign bus.AES_MSG_ENC = enc_r;
endmodule

// File: tb/tb_aes_encrypt.sv
// Directed bench for aes_encrypt using FIPS-197 vectors, handshake, reset and back-to-back cases.
module tb_aes_encrypt;
`ifdef AES_ENC_FAST_MIX_EN
    localparam int LAT = 40;
`else
    localparam int LAT = 67;
`endif
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails = 0;
    logic [127:0] pre_enc;

    always #5 clk = ~clk;

    aes_encrypt_if bus ();
    aes_encrypt dut (.CLK(clk), .RESET(rst), .bus(bus));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a block from IDLE and wait (bounded) for DONE; pre returns the output just before completion
    task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] ct, input bit scramble, output logic [127:0] pre);
        int n;
        bus.AES_KEY     = key;
        bus.AES_MSG_DEC = pt;
        bus.AES_START   = 1'b1;
        tick();
        n   = 0;
        pre = bus.AES_MSG_ENC;
        while (bus.AES_DONE !== 1'b1 && n < 200) begin
            if (scramble && n == 10) begin
                bus.AES_KEY     = ~key;
                bus.AES_MSG_DEC = ~pt;
            end
            if (n == LAT - 1) pre = bus.AES_MSG_ENC;
            tick();
            n++;
        end
        chk({tag, " latency"}, 128'(n), 128'(LAT));
        chk({tag, " ciphertext"}, bus.AES_MSG_ENC, ct);
    endtask

    initial begin
        int rises;
        logic prev;
        bus.AES_START   = 1'b0;
        bus.AES_KEY     = 128'h0;
        bus.AES_MSG_DEC = 128'h0;
        repeat (3) tick();
        chk("reset done", 128'(bus.AES_DONE), 128'h0);
        chk("reset enc", bus.AES_MSG_ENC, 128'h0);
        rst = 1'b0;
        tick();

        // App. B, then hold START and release
        run_block("appB", KEY_B, PT_B, CT_B, 1'b0, pre_enc);
        repeat (5) tick();
        chk("done held", 128'(bus.AES_DONE), 128'h1);
        bus.AES_START = 1'b0;
        tick();
        chk("done fall", 128'(bus.AES_DONE), 128'h0);
        chk("enc held idle", bus.AES_MSG_ENC, CT_B);

        // START held 200 cycles gives exactly one completion
        bus.AES_START = 1'b1;
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.AES_DONE === 1'b1 && prev !== 1'b1) rises++;
            prev = bus.AES_DONE;
        end
        chk("single run rises", 128'(rises), 128'h1);
        chk("hold done high", 128'(bus.AES_DONE), 128'h1);
        chk("hold enc", bus.AES_MSG_ENC, CT_B);
        bus.AES_START = 1'b0;
        tick();
        chk("hold done fall", 128'(bus.AES_DONE), 128'h0);

        // App. C.1 with inputs changed mid-run
        run_block("appC scrambled", KEY_C, PT_C, CT_C, 1'b1, pre_enc);
        chk("enc before C", pre_enc, CT_B);
        bus.AES_START = 1'b0;
        tick();

        // Back-to-back with one low cycle of START between
        run_block("b2b B", KEY_B, PT_B, CT_B, 1'b0, pre_enc);
        chk("b2b enc before B", pre_enc, CT_C);
        bus.AES_START = 1'b0;
        tick();
        chk("b2b done fall", 128'(bus.AES_DONE), 128'h0);
        run_block("b2b C", KEY_C, PT_C, CT_C, 1'b0, pre_enc);
        chk("b2b enc held B", pre_enc, CT_B);
        bus.AES_START = 1'b0;
        tick();

        // Reset at E0+30, then restart App. B
        bus.AES_KEY     = KEY_B;
        bus.AES_MSG_DEC = PT_B;
        bus.AES_START   = 1'b1;
        tick();
        repeat (30) tick();
        rst = 1'b1;
        #1;
        chk("midrst done", 128'(bus.AES_DONE), 128'h0);
        chk("midrst enc", bus.AES_MSG_ENC, 128'h0);
        bus.AES_START = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("post rst idle", 128'(bus.AES_DONE), 128'h0);
        run_block("restart B", KEY_B, PT_B, CT_B, 1'b0, pre_enc);
        chk("restart enc before", pre_enc, 128'h0);
        bus.AES_START = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
